// File: rtl/radar_pkg.sv
// ============================================================================
// Module      : radar_pkg
// Description : Shared types and limits for the synthetic radar signal source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package radar_pkg;

    localparam int RADAR_DATA_WIDTH = 32;

    // Smallest values that still leave a low gap after every 1 us pulse
    localparam int MIN_ARP_US  = 2;
    localparam int MIN_TRIG_US = 2;
    localparam int MIN_ACP_CNT = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } radar_state_e;

endpackage

`default_nettype wire

// File: rtl/radar_signal_gen_if.sv
// ============================================================================
// Module      : radar_signal_gen_if
// Description : Configuration inputs and pulse outputs of radar_signal_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import radar_pkg::*;

interface radar_signal_gen_if #(
    parameter int DATA_WIDTH = RADAR_DATA_WIDTH
);
    logic                  US_CLK;
    logic                  EN;
    logic [DATA_WIDTH-1:0] ARP_US;
    logic [DATA_WIDTH-1:0] ACP_CNT;
    logic [DATA_WIDTH-1:0] TRIG_US;
    logic                  ARP;
    logic                  ACP;
    logic                  TRIG;
    logic [DATA_WIDTH-1:0] ACP_IDX;
    logic                  RUNNING;
    logic                  CFG_ERR;

    modport master (
        output US_CLK, EN, ARP_US, ACP_CNT, TRIG_US,
        input  ARP, ACP, TRIG, ACP_IDX, RUNNING, CFG_ERR
    );

    modport slave (
        input  US_CLK, EN, ARP_US, ACP_CNT, TRIG_US,
        output ARP, ACP, TRIG, ACP_IDX, RUNNING, CFG_ERR
    );
endinterface

`default_nettype wire

// File: rtl/radar_acp_spacer.sv
// ============================================================================
// Module      : radar_acp_spacer
// Description : Bresenham-style ACP placement: ACP_CNT pulses per ARP_US ticks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import radar_pkg::*;

module radar_acp_spacer #(
    parameter int DATA_WIDTH = RADAR_DATA_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  tick_i,
    input  wire logic                  start_i,
    input  wire logic                  adv_i,
    input  wire logic [DATA_WIDTH-1:0] acp_cnt_i,
    input  wire logic [DATA_WIDTH-1:0] arp_us_i,
    output logic                       acp_o,
    output logic [DATA_WIDTH-1:0]      acp_idx_o
);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d;
    logic                  acp_q, acp_d;
    logic [DATA_WIDTH:0]   sum;

    // One extra bit so acc + ACP_CNT can never wrap
    assign sum = {1'b0, acc_q} + {1'b0, acp_cnt_i};

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        acp_d = acp_q;
        if (tick_i) begin
            acp_d = 1'b0;
            if (start_i) begin
                acc_d = '0;
                idx_d = '0;
                acp_d = 1'b1;
            end else if (adv_i) begin
                if (sum >= {1'b0, arp_us_i}) begin
                    acc_d = sum[DATA_WIDTH-1:0] - arp_us_i;
                    idx_d = idx_q + DATA_WIDTH'(1);
                    acp_d = 1'b1;
                end else begin
                    acc_d = sum[DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            idx_q <= '0;
            acp_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            acp_q <= acp_d;
        end
    end

    assign acp_o     = acp_q;
    assign acp_idx_o = idx_q;

endmodule

`default_nettype wire

// File: rtl/radar_signal_gen.sv
// ============================================================================
// Module      : radar_signal_gen
// Description : Synthetic ARP/ACP/TRIG pulse source timed in US_CLK ticks.
//               Build option RADAR_GEN_TRIG_SYNC_EN phase-locks TRIG to ARP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import radar_pkg::*;

module radar_signal_gen #(
    parameter int DATA_WIDTH = RADAR_DATA_WIDTH
) (
    input  wire logic         SYS_CLK,
    input  wire logic         RST,
    radar_signal_gen_if.slave bus
);

    radar_state_e          state_q, state_d;
    logic                  us_q;
    logic                  tick;
    logic [DATA_WIDTH-1:0] arp_us_q, arp_us_d;
    logic [DATA_WIDTH-1:0] acp_cnt_q, acp_cnt_d;
    logic [DATA_WIDTH-1:0] trig_us_q, trig_us_d;
    logic [DATA_WIDTH-1:0] us_cnt_q, us_cnt_d;
    logic [DATA_WIDTH-1:0] trig_cnt_q, trig_cnt_d;
    logic [DATA_WIDTH-1:0] trig_next;
    logic                  arp_q, arp_d;
    logic                  trig_q, trig_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  cfg_ok;
    logic                  rot_start;
    logic                  adv;

    assign tick = bus.US_CLK & ~us_q;

    assign cfg_ok = (bus.ARP_US  >= DATA_WIDTH'(MIN_ARP_US))  &&
                    (bus.TRIG_US >= DATA_WIDTH'(MIN_TRIG_US)) &&
                    (bus.ACP_CNT >= DATA_WIDTH'(MIN_ACP_CNT)) &&
                    (bus.ACP_CNT <= (bus.ARP_US >> 1));

    assign trig_next = (trig_cnt_q == trig_us_q - DATA_WIDTH'(1)) ? '0
                                                                  : trig_cnt_q + DATA_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        arp_us_d   = arp_us_q;
        acp_cnt_d  = acp_cnt_q;
        trig_us_d  = trig_us_q;
        us_cnt_d   = us_cnt_q;
        trig_cnt_d = trig_cnt_q;
        arp_d      = arp_q;
        trig_d     = trig_q;
        cfg_err_d  = cfg_err_q;
        rot_start  = 1'b0;
        adv        = 1'b0;
        if (tick) begin
            arp_d  = 1'b0;
            trig_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.EN) begin
                        if (cfg_ok) begin
                            state_d    = ST_RUN;
                            arp_us_d   = bus.ARP_US;
                            acp_cnt_d  = bus.ACP_CNT;
                            trig_us_d  = bus.TRIG_US;
                            cfg_err_d  = 1'b0;
                            rot_start  = 1'b1;
                            us_cnt_d   = '0;
                            trig_cnt_d = '0;
                            arp_d      = 1'b1;
                            trig_d     = 1'b1;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (us_cnt_q == arp_us_q - DATA_WIDTH'(1)) begin
                        // Rotation boundary: leaving RUN emits nothing on this tick
                        if (!bus.EN) begin
                            state_d = ST_IDLE;
                        end else if (!cfg_ok) begin
                            state_d   = ST_IDLE;
                            cfg_err_d = 1'b1;
                        end else begin
                            arp_us_d  = bus.ARP_US;
                            acp_cnt_d = bus.ACP_CNT;
                            trig_us_d = bus.TRIG_US;
                            rot_start = 1'b1;
                            us_cnt_d  = '0;
                            arp_d     = 1'b1;
`ifdef RADAR_GEN_TRIG_SYNC_EN
                            trig_cnt_d = '0;
`else
                            trig_cnt_d = trig_next;
`endif
                            trig_d = (trig_cnt_d == '0);
                        end
                    end else begin
                        us_cnt_d   = us_cnt_q + DATA_WIDTH'(1);
                        adv        = 1'b1;
                        trig_cnt_d = trig_next;
                        trig_d     = (trig_next == '0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            us_q       <= 1'b0;
            arp_us_q   <= '0;
            acp_cnt_q  <= '0;
            trig_us_q  <= '0;
            us_cnt_q   <= '0;
            trig_cnt_q <= '0;
            arp_q      <= 1'b0;
            trig_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            us_q       <= bus.US_CLK;
            arp_us_q   <= arp_us_d;
            acp_cnt_q  <= acp_cnt_d;
            trig_us_q  <= trig_us_d;
            us_cnt_q   <= us_cnt_d;
            trig_cnt_q <= trig_cnt_d;
            arp_q      <= arp_d;
            trig_q     <= trig_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Spacer sees the shadowed config, so mid-rotation edits cannot disturb it
    radar_acp_spacer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_acp_spacer (
        .clk       (SYS_CLK),
        .rst       (RST),
        .tick_i    (tick),
        .start_i   (rot_start),
        .adv_i     (adv),
        .acp_cnt_i (acp_cnt_q),
        .arp_us_i  (arp_us_q),
        .acp_o     (bus.ACP),
        .acp_idx_o (bus.ACP_IDX)
    );

    assign bus.ARP     = arp_q;
    assign bus.TRIG    = trig_q;
    assign bus.RUNNING = (state_q == ST_RUN);
    assign bus.CFG_ERR = cfg_err_q;

endmodule

`default_nettype wire
